matrix_result_serializer: RTL and testbench
===========================================

// Module: matrix_result_serializer
// PURPOSE
//  Downstream end of the 4x4 complex matrix multiplier. Accepts product rows as two beats. Each beat
//  carries a row pair (c = upper row, d = lower row) with a done/valid strobe. Assembles the full 4x4
//  result, then streams it out one complex element per cycle over a valid/ready interface.
//  Order is row-major, with row/col tags and a last flag. Sits between matrix_mul_ctrl and the
//  result consumer (DMA/UART packer).
// PARAMETERS
//  INTEGER_SIZE  6   integer bits of signed fixed-point element
//  FRACT_SIZE    12  fraction bits of element
//  DATA_WIDTH    18  INTEGER_SIZE+FRACT_SIZE; width of each real/imag part
// PORTS
//  clk        in   1             single clock, all logic on rising edge
//  rst        in   1             synchronous, active-high reset
//  in_valid   in   1             row-pair beat present (driven by multiplier done)
//  in_ready   out  1             serializer can accept a beat
//  c_row_r    in   4*DATA_WIDTH  upper row real parts; element k (k=1..4) at [k*DW-1:(k-1)*DW]
//  c_row_i    in   4*DATA_WIDTH  upper row imag parts, same packing
//  d_row_r    in   4*DATA_WIDTH  lower row real parts, same packing
//  d_row_i    in   4*DATA_WIDTH  lower row imag parts, same packing
//  abort      in   1             synchronous flush to IDLE, discards partial/pending matrix
//  out_valid  out  1             element on out_* is valid
//  out_ready  in   1             consumer accepts element
//  out_r      out  DATA_WIDTH    element real part
//  out_i      out  DATA_WIDTH    element imag part
//  out_row    out  2             element row index 0..3
//  out_col    out  2             element column index 0..3
//  out_last   out  1             high with element (3,3)
//  busy       out  1             state != IDLE
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE. in_ready=1. out_valid=0, out_last=0. out_r=out_i=0,
//    out_row=out_col=0. busy=0. All 32 buffer words cleared to 0. Reset wins over every other input.
//  - Beat accepted when in_valid & in_ready. No data transform: widths are preserved, no rounding.
//  - FSM:
//    IDLE:  in_ready=1. On beat: c->row0, d->row1. Go to HALF.
//    HALF:  in_ready=1. On beat: c->row2, d->row3. Go to DRAIN, idx=0.
//    DRAIN: in_ready=0, out_valid=1.
//           - On out_valid & out_ready: idx++.
//           - If idx==15 when accepted: go to IDLE; out_valid falls the next cycle.
//  - Latency: out_valid rises the first cycle after the second beat is accepted. Drain takes
//    exactly 16 cycles when out_ready is held at 1.
//  - Element mapping: out_row=idx[3:2], out_col=idx[1:0]. out_r/out_i = buffer[idx] (registered
//    buffer, combinational mux). out_last = (idx==15) & out_valid.
//  - Backpressure: while out_valid & !out_ready, all out_* stay stable. Idx does not advance.
//  - In DRAIN, in_valid is ignored (in_ready=0). The multiplier holds its beat until IDLE; the beat
//    presented in the cycle after the last accept is taken.
//  - abort=1: go to IDLE next cycle, out_valid=0, idx=0. Buffer contents are not cleared.
//    If abort coincides with an in_valid beat, abort wins and the beat is not captured.
//  - No overflow or error state: the beat count is enforced purely by in_ready.
// STRUCTURE
//  - Shared package matrix_mul_pkg: DATA_WIDTH/INTEGER_SIZE/FRACT_SIZE defaults, FSM state
//    encoding (IDLE=2'd0, HALF=2'd1, DRAIN=2'd2), IDX_W=4, MAT_N=4.
//  - One sub-module: mat_elem_mux, a 16:1 complex element selector (buffer, idx -> out_r/out_i).
//    FSM and buffer stay in the top level.
// TESTING
//  1. Reset: hold rst 2 cycles -> in_ready=1, out_valid=0, busy=0, all outputs 0.
//  2. Full frame: beat0 c row = 1+1i..4+4i, d row = 5+5i..8+8i; beat1 = 9+9i..16+16i.
//     out_ready=1 -> out_valid rises 1 cycle after beat1. Outputs are 1..16 in order,
//     row/col 0,0..3,3. out_last only on 16+16i; back to IDLE after.
//  3. Backpressure: same frame; toggle out_ready 1,0,0,1,... -> no element dropped or duplicated.
//     Data and tags are stable while stalled; exactly 16 accepts.
//  4. Back-to-back: in_valid held high with a 2nd frame during DRAIN -> in_ready=0 throughout.
//     2nd frame beat0 is captured the cycle after the 1st frame's last accept.
//  5. Abort: abort in HALF after one beat -> IDLE. Next two beats form a clean frame (no stale
//     rows). Abort mid-DRAIN at idx=5 -> out_valid=0 next cycle.
//  6. Reset mid-DRAIN at idx=9 -> all outputs 0 next cycle. A following full frame streams correctly.

Source files
------------

// File: rtl/matrix_mul_pkg.sv
// Shared constants and FSM encoding for the 4x4 complex matrix multiplier datapath.
package matrix_mul_pkg;

    // Default fixed-point format of one real or imaginary part (signed Q6.12).
    localparam int DEF_INTEGER_SIZE = 6;
    localparam int DEF_FRACT_SIZE   = 12;
    localparam int DEF_DATA_WIDTH   = DEF_INTEGER_SIZE + DEF_FRACT_SIZE;

    // Matrix geometry: 4x4 elements, addressed by a 4-bit row-major index.
    localparam int MAT_N  = 4;
    localparam int N_ELEM = MAT_N * MAT_N;
    localparam int IDX_W  = 4;

    // Index of the final element (3,3).
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);

    // Serializer states: collect first row pair, collect second row pair, stream out.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HALF  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mat_elem_mux.sv
// 16:1 complex element selector: picks buffer[idx] for the real and imaginary planes.
module mat_elem_mux
    import matrix_mul_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_buf_r [N_ELEM],
    input  logic [DATA_WIDTH-1:0] i_buf_i [N_ELEM],
    input  logic [IDX_W-1:0]      i_idx,
    output logic [DATA_WIDTH-1:0] o_r,
    output logic [DATA_WIDTH-1:0] o_i
);

    // Combinational read of the selected element; the buffer itself is registered upstream.
    always_comb begin
        o_r = i_buf_r[i_idx];
        o_i = i_buf_i[i_idx];
    end

endmodule

// File: rtl/matrix_result_serializer.sv
// Collects a 4x4 complex product delivered as two row-pair beats, then streams it out
// one element per cycle in row-major order with row/col tags and a last flag.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and ready are
// both high. The upstream side holds its beat until in_ready; the downstream side sees
// out_* held stable while out_valid is high and out_ready is low.
module matrix_result_serializer
    import matrix_mul_pkg::*;
#(
    parameter int INTEGER_SIZE = DEF_INTEGER_SIZE,
    parameter int FRACT_SIZE   = DEF_FRACT_SIZE,
    parameter int DATA_WIDTH   = INTEGER_SIZE + FRACT_SIZE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*DATA_WIDTH-1:0]   c_row_r,
    input  logic [4*DATA_WIDTH-1:0]   c_row_i,
    input  logic [4*DATA_WIDTH-1:0]   d_row_r,
    input  logic [4*DATA_WIDTH-1:0]   d_row_i,
    input  logic                      abort,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_r,
    output logic [DATA_WIDTH-1:0]     out_i,
    output logic [1:0]                out_row,
    output logic [1:0]                out_col,
    output logic                      out_last,
    output logic                      busy
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_load_lo;
    logic                  w_load_hi;
    logic                  w_in_ready;
    logic                  w_out_valid;

    logic [DATA_WIDTH-1:0] r_buf_r [N_ELEM];
    logic [DATA_WIDTH-1:0] r_buf_i [N_ELEM];

    // State and drain index registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state, index update, buffer load strobes and handshake outputs; abort wins over a beat.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load_lo   = 1'b0;
        w_load_hi   = 1'b0;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_load_lo   = 1'b1;
                    w_state_nxt = ST_HALF;
                end
            end
            ST_HALF: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_load_hi   = 1'b1;
                    w_state_nxt = ST_DRAIN;
                    w_idx_nxt   = '0;
                end
            end
            ST_DRAIN: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    // Index wraps to 0 after element 15, ready for the next frame.
                    w_idx_nxt = r_idx + IDX_W'(1);
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
            w_load_lo   = 1'b0;
            w_load_hi   = 1'b0;
        end
    end

    // Result buffer: beat 0 fills rows 0/1, beat 1 fills rows 2/3; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < N_ELEM; e++) begin
                r_buf_r[e] <= '0;
                r_buf_i[e] <= '0;
            end
        end else begin
            for (int k = 0; k < MAT_N; k++) begin
                if (w_load_lo) begin
                    r_buf_r[k]         <= c_row_r[k*DATA_WIDTH +: DATA_WIDTH];
                    r_buf_i[k]         <= c_row_i[k*DATA_WIDTH +: DATA_WIDTH];
                    r_buf_r[MAT_N + k] <= d_row_r[k*DATA_WIDTH +: DATA_WIDTH];
                    r_buf_i[MAT_N + k] <= d_row_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
                if (w_load_hi) begin
                    r_buf_r[2*MAT_N + k] <= c_row_r[k*DATA_WIDTH +: DATA_WIDTH];
                    r_buf_i[2*MAT_N + k] <= c_row_i[k*DATA_WIDTH +: DATA_WIDTH];
                    r_buf_r[3*MAT_N + k] <= d_row_r[k*DATA_WIDTH +: DATA_WIDTH];
                    r_buf_i[3*MAT_N + k] <= d_row_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    mat_elem_mux #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .i_buf_r (r_buf_r),
        .i_buf_i (r_buf_i),
        .i_idx   (r_idx),
        .o_r     (out_r),
        .o_i     (out_i)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_row   = r_idx[3:2];
    assign out_col   = r_idx[1:0];
    assign out_last  = (r_idx == IDX_LAST) & w_out_valid;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Bench for matrix_result_serializer: frames are held as plain 4x4 arrays, the expected
// stream is the row-major walk of that array, and each task checks one scenario.
module tb_matrix_result_serializer;

  localparam int DW = 18;
  localparam int EW = 2 + 2 + DW + DW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            abort = 1'b0;
  logic            out_ready = 1'b0;
  logic [4*DW-1:0] c_row_r = '0;
  logic [4*DW-1:0] c_row_i = '0;
  logic [4*DW-1:0] d_row_r = '0;
  logic [4*DW-1:0] d_row_i = '0;
  logic            in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_r;
  logic [DW-1:0]   out_i;
  logic [1:0]      out_row;
  logic [1:0]      out_col;
  logic            out_last;
  logic            busy;

  matrix_result_serializer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c_row_r   (c_row_r),
    .c_row_i   (c_row_i),
    .d_row_r   (d_row_r),
    .d_row_i   (d_row_i),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .busy      (busy)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] fr_r [2][16];
  logic [DW-1:0] fr_i [2][16];
  logic [EW-1:0] exp_q [$];
  logic [EW-1:0] got;
  int n_checks = 0;
  int n_fail = 0;
  int acc;
  int cyc;

  task automatic load_seq_frame(input int f);
    for (int k = 0; k < 16; k++) begin
      fr_r[f][k] = DW'((k + 1) << 12);
      fr_i[f][k] = DW'((k + 1) << 12);
    end
  endtask

  task automatic load_rand_frame(input int f);
    for (int k = 0; k < 16; k++) begin
      fr_r[f][k] = DW'($urandom);
      fr_i[f][k] = DW'($urandom);
    end
  endtask

  // Expected stream: walk the matrix row by row; last flag only on (3,3).
  task automatic build_exp(input int f);
    exp_q.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_q.push_back({2'(r), 2'(c), fr_r[f][r*4+c], fr_i[f][r*4+c], (r == 3 && c == 3)});
  endtask

  // ---------------- driver tasks ----------------
  // Beat b carries matrix rows 2b (c) and 2b+1 (d); column k sits in slice k.
  task automatic set_beat(input int f, input int b);
    for (int k = 0; k < 4; k++) begin
      c_row_r[k*DW +: DW] = fr_r[f][(2*b)*4 + k];
      c_row_i[k*DW +: DW] = fr_i[f][(2*b)*4 + k];
      d_row_r[k*DW +: DW] = fr_r[f][(2*b+1)*4 + k];
      d_row_i[k*DW +: DW] = fr_i[f][(2*b+1)*4 + k];
    end
  endtask

  // Present a beat at a falling edge and hold it until a rising edge sees in_ready.
  task automatic drive_beat(input int f, input int b);
    bit done;
    done = 1'b0;
    set_beat(f, b);
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      done = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_timeout frame=%0d beat=%0d in_ready stayed 0, required 1", f, b);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, busy, out_last, out_row, out_col, out_r, out_i} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, {DW{1'b0}}, {DW{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b v=%b busy=%b last=%b row=%0d col=%0d r=%h i=%h, required rdy=1 others 0",
               in_ready, out_valid, busy, out_last, out_row, out_col, out_r, out_i);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    load_seq_frame(0);
    build_exp(0);
    out_ready = 1'b1;
    drive_beat(0, 0);
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL half_state got v=%b busy=%b rdy=%b, required v=0 busy=1 rdy=1", out_valid, busy, in_ready);
    end
    drive_beat(0, 1);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL drain_latency got v=%b rdy=%b, required v=1 rdy=0", out_valid, in_ready);
    end
    acc = 0; cyc = 0;
    while (acc < 16 && cyc < 200) begin
      out_ready = 1'b1;
      if (out_valid) begin
        got = {out_row, out_col, out_r, out_i, out_last};
        n_checks++;
        if (got !== exp_q[0]) begin
          n_fail++;
          $display("FAIL full_elem n=%0d got=%h required=%h", acc, got, exp_q[0]);
        end
        void'(exp_q.pop_front());
        acc++;
      end
      @(negedge clk); cyc++;
    end
    n_checks++;
    if (acc != 16 || cyc != 16 || out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL full_end accepts=%0d cycles=%0d v=%b busy=%b last=%b, required 16/16/0/0/0", acc, cyc, out_valid, busy, out_last);
    end
  endtask

  task automatic test_backpressure(input bit random_ready);
    if (random_ready) load_rand_frame(0); else load_seq_frame(0);
    build_exp(0);
    drive_beat(0, 0);
    drive_beat(0, 1);
    acc = 0; cyc = 0;
    while (acc < 16 && cyc < 400) begin
      out_ready = random_ready ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
      if (out_valid) begin
        got = {out_row, out_col, out_r, out_i, out_last};
        n_checks++;
        if (got !== exp_q[0]) begin
          n_fail++;
          $display("FAIL bp_elem n=%0d cyc=%0d got=%h required=%h", acc, cyc, got, exp_q[0]);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          acc++;
        end
      end
      @(negedge clk); cyc++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (acc != 16 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_end accepts=%0d v=%b busy=%b, required 16/0/0", acc, out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    load_rand_frame(0);
    load_rand_frame(1);
    build_exp(0);
    drive_beat(0, 0);
    drive_beat(0, 1);
    set_beat(1, 0);
    in_valid = 1'b1;
    acc = 0; cyc = 0;
    while (acc < 16 && cyc < 200) begin
      out_ready = 1'b1;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_in_ready cyc=%0d got=%b required=0", cyc, in_ready);
      end
      if (out_valid) begin
        got = {out_row, out_col, out_r, out_i, out_last};
        n_checks++;
        if (got !== exp_q[0]) begin
          n_fail++;
          $display("FAIL b2b_elem_a n=%0d got=%h required=%h", acc, got, exp_q[0]);
        end
        void'(exp_q.pop_front());
        acc++;
      end
      @(negedge clk); cyc++;
    end
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL b2b_idle got v=%b busy=%b rdy=%b, required v=0 busy=0 rdy=1", out_valid, busy, in_ready);
    end
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL b2b_capture got v=%b busy=%b rdy=%b, required v=0 busy=1 rdy=1", out_valid, busy, in_ready);
    end
    drive_beat(1, 1);
    build_exp(1);
    acc = 0; cyc = 0;
    while (acc < 16 && cyc < 200) begin
      out_ready = 1'b1;
      if (out_valid) begin
        got = {out_row, out_col, out_r, out_i, out_last};
        n_checks++;
        if (got !== exp_q[0]) begin
          n_fail++;
          $display("FAIL b2b_elem_b n=%0d got=%h required=%h", acc, got, exp_q[0]);
        end
        void'(exp_q.pop_front());
        acc++;
      end
      @(negedge clk); cyc++;
    end
    n_checks++;
    if (acc != 16 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end accepts=%0d busy=%b, required 16/0", acc, busy);
    end
  endtask

  task automatic test_abort();
    // Abort in HALF, coinciding with a second beat: the beat must be dropped.
    load_rand_frame(0);
    drive_beat(0, 0);
    set_beat(0, 1);
    in_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL abort_half got v=%b busy=%b rdy=%b, required v=0 busy=0 rdy=1", out_valid, busy, in_ready);
    end
    load_rand_frame(1);
    build_exp(1);
    drive_beat(1, 0);
    drive_beat(1, 1);
    acc = 0; cyc = 0;
    while (acc < 16 && cyc < 200) begin
      out_ready = 1'b1;
      if (out_valid) begin
        got = {out_row, out_col, out_r, out_i, out_last};
        n_checks++;
        if (got !== exp_q[0]) begin
          n_fail++;
          $display("FAIL abort_clean_elem n=%0d got=%h required=%h", acc, got, exp_q[0]);
        end
        void'(exp_q.pop_front());
        acc++;
      end
      @(negedge clk); cyc++;
    end
    n_checks++;
    if (acc != 16) begin
      n_fail++;
      $display("FAIL abort_clean_count accepts=%0d required=16", acc);
    end
    // Abort in DRAIN while element 5 is presented.
    load_rand_frame(0);
    build_exp(0);
    drive_beat(0, 0);
    drive_beat(0, 1);
    acc = 0; cyc = 0;
    while (acc < 5 && cyc < 200) begin
      out_ready = 1'b1;
      if (out_valid) begin
        void'(exp_q.pop_front());
        acc++;
      end
      @(negedge clk); cyc++;
    end
    got = {out_row, out_col, out_r, out_i, out_last};
    n_checks++;
    if (out_valid !== 1'b1 || got !== exp_q[0]) begin
      n_fail++;
      $display("FAIL abort_idx5_elem v=%b got=%h required v=1 %h", out_valid, got, exp_q[0]);
    end
    out_ready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({out_valid, busy, out_last, out_row, out_col} !== {3'b000, 2'd0, 2'd0}) begin
      n_fail++;
      $display("FAIL abort_drain got v=%b busy=%b last=%b row=%0d col=%0d, required all 0", out_valid, busy, out_last, out_row, out_col);
    end
  endtask

  task automatic test_reset_mid_drain();
    load_rand_frame(0);
    build_exp(0);
    drive_beat(0, 0);
    drive_beat(0, 1);
    acc = 0; cyc = 0;
    while (acc < 9 && cyc < 200) begin
      out_ready = 1'b1;
      if (out_valid) begin
        void'(exp_q.pop_front());
        acc++;
      end
      @(negedge clk); cyc++;
    end
    n_checks++;
    if ({out_valid, out_row, out_col} !== {1'b1, 2'd2, 2'd1}) begin
      n_fail++;
      $display("FAIL rst_pre_idx9 got v=%b row=%0d col=%0d, required v=1 row=2 col=1", out_valid, out_row, out_col);
    end
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, busy, out_last, out_row, out_col, out_r, out_i} !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, {DW{1'b0}}, {DW{1'b0}}}) begin
      n_fail++;
      $display("FAIL rst_mid_drain got rdy=%b v=%b busy=%b last=%b row=%0d col=%0d r=%h i=%h, required rdy=1 others 0",
               in_ready, out_valid, busy, out_last, out_row, out_col, out_r, out_i);
    end
    load_rand_frame(1);
    build_exp(1);
    drive_beat(1, 0);
    drive_beat(1, 1);
    acc = 0; cyc = 0;
    while (acc < 16 && cyc < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid) begin
        got = {out_row, out_col, out_r, out_i, out_last};
        n_checks++;
        if (got !== exp_q[0]) begin
          n_fail++;
          $display("FAIL rst_after_elem n=%0d got=%h required=%h", acc, got, exp_q[0]);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          acc++;
        end
      end
      @(negedge clk); cyc++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (acc != 16 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after_end accepts=%0d busy=%b, required 16/0", acc, busy);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_frame();
    test_backpressure(1'b0);
    test_backpressure(1'b1);
    test_back_to_back();
    test_abort();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
